// File: rtl/mux_demux_dispatch.sv
// Registered 1-to-2 demultiplexer: steers each accepted word into one of two
// independent FIFOs, each draining through its own valid/ready port.
module mux_demux_dispatch #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           din,
    input  logic                       sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           dout_0,
    output logic                       valid_0,
    input  logic                       ready_0,
    output logic [WIDTH-1:0]           dout_1,
    output logic                       valid_1,
    input  logic                       ready_1,
    output logic [$clog2(DEPTH+1)-1:0] count_0,
    output logic [$clog2(DEPTH+1)-1:0] count_1
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [2][DEPTH];
    logic [PW-1:0]    wp  [2];
    logic [PW-1:0]    rp  [2];
    logic [CW-1:0]    cnt [2];
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       rdy;

    // Admission looks only at the selected FIFO's occupancy; a pop in the
    // same cycle does not free a slot for a full FIFO.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        in_ready = 1'b0;
        push     = 2'b00;
        pop      = 2'b00;
        rdy      = {ready_1, ready_0};
        in_ready = (sel ? cnt[1] : cnt[0]) != CW'(DEPTH);
        push[0]  = in_valid && in_ready && !sel;
        push[1]  = in_valid && in_ready &&  sel;
        for (int k = 0; k < 2; k++) begin
            pop[k] = (cnt[k] != '0) && rdy[k];
        end
    end

    // NOTE: storage is reset along with the pointers so dout reads 0 after
    // reset rather than stale data; this costs a reset net on every cell.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                wp[k]  <= '0;
                rp[k]  <= '0;
                cnt[k] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem[k][i] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    mem[k][wp[k]] <= din;
                    wp[k]         <= wp[k] + PW'(1);
                end
                if (pop[k]) begin
                    rp[k] <= rp[k] + PW'(1);
                end
                case ({push[k], pop[k]})
                    2'b10:   cnt[k] <= cnt[k] + CW'(1);
                    2'b01:   cnt[k] <= cnt[k] - CW'(1);
                    default: cnt[k] <= cnt[k];
                endcase
            end
        end
    end

    assign dout_0  = mem[0][rp[0]];
    assign dout_1  = mem[1][rp[1]];
    assign valid_0 = (cnt[0] != '0);
    assign valid_1 = (cnt[1] != '0);
    assign count_0 = cnt[0];
    assign count_1 = cnt[1];

endmodule
